br_inject_arbiter: RTL and testbench
====================================

BR_INJECT_ARBITER -- requirements
Module: br_inject_arbiter

Interface
REQ-001 Parameter REQ_CNT, default 4, number of local requesters sharing one BrLite local injection port (range 2..16).
REQ-002 Parameter SRC_ADDR, default 0, PE address placed in seq_source of every injected flit.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  REQ_CNT  per-requester injection request, held high with payload stable until acked.
REQ-006 payload_i  input  REQ_CNT x br_payload_t  per-requester payload.
REQ-007 clear_i  input  REQ_CNT  per-requester clear flag.
REQ-008 ack_o  output  REQ_CNT  one-cycle pulse to the requester whose flit the NoC accepted.
REQ-009 flit_o  output  br_data_t  flit toward NoC local port (seq_source, payload, clear, id).
REQ-010 req_o  output  1  request toward NoC local port.
REQ-011 ack_i  input  1  NoC acceptance of flit_o.
REQ-012 busy_i  input  1  NoC local port busy; no new grant while high.
REQ-013 grant_o  output  $clog2(REQ_CNT)  index of current/last granted requester.

Function
REQ-014 FSM states IDLE, SEND; reset state IDLE.
REQ-015 IDLE: if any req_i high and busy_i low, select requester by round-robin starting at rr_ptr, latch its payload/clear into flit_o with id=id_cnt, seq_source=SRC_ADDR, set grant_o, assert req_o next cycle, go SEND.
REQ-016 IDLE with busy_i high or no req_i: stay IDLE, req_o low, flit_o held.
REQ-017 SEND: hold req_o and flit_o stable until ack_i sampled high.
REQ-018 SEND with ack_i high: deassert req_o next cycle, pulse ack_o[grant] one cycle, id_cnt+1, rr_ptr = grant+1 mod REQ_CNT, go IDLE.
REQ-019 busy_i changes during SEND are ignored; committed flit completes.
REQ-020 Requester deasserting req_i while not granted is simply skipped; deasserting after grant does not cancel the flit.
REQ-021 id_cnt is 5 bits, wraps 31 -> 0 with no flag.
REQ-022 rr_ptr wraps REQ_CNT-1 -> 0; lone requester is granted every slot.
REQ-023 Minimum latency req_i high -> req_o high: 1 cycle; back-to-back injections separated by at least one IDLE cycle.
REQ-024 At most one bit of ack_o high in any cycle; never more than one outstanding flit.

Reset
REQ-025 rst_i high forces immediately: state IDLE, req_o 0, ack_o 0, flit_o 0, grant_o 0, id_cnt 0, rr_ptr 0.
REQ-026 Reset during SEND abandons the flit; no ack_o issued; requester re-requests after reset.

Configuration
REQ-027 Macro BR_INJ_STATS_EN: when defined, adds output inj_cnt_o (32 bits, reset 0) incrementing on every NoC ack_i in SEND, saturating at all-ones; when undefined, port and counter are absent and behaviour is otherwise identical.

Structure
REQ-028 br_data_t, br_payload_t and the 5-bit id width live in BrLitePkg; FSM state enum added there as br_inj_state_t.
REQ-029 Round-robin selection is a sub-module br_rr_arbiter (inputs request vector, pointer; outputs one-hot grant, index, valid), purely combinational.

Verification
REQ-030 Single requester 2, SRC_ADDR=5, payload 0xABCD, ack_i 2 cycles after req_o -> flit_o.seq_source=5, id=0, ack_o=4'b0100 one cycle, req_o low next cycle.
REQ-031 All 4 requesters high continuously, immediate ack -> grant order 0,1,2,3,0; ids 0..4.
REQ-032 busy_i held high 10 cycles with req_i[1] high -> req_o stays 0; grant 1 cycle after busy_i falls.
REQ-033 33 injections from requester 0 -> id sequence 0..31,0.
REQ-034 rst_i asserted mid-SEND -> req_o 0 same cycle, no ack_o, next flit id=0.
REQ-035 With BR_INJ_STATS_EN, 7 acked injections -> inj_cnt_o=7; without it, bench compiles without the port.

Source files
------------

// File: rtl/br_inject_arbiter_pkg.sv
// BrLite shared types: flit layout, payload type and injection FSM state encoding.
package BrLitePkg;

   localparam int unsigned BR_ID_W      = 5;
   localparam int unsigned BR_ADDR_W    = 8;
   localparam int unsigned BR_PAYLOAD_W = 16;

   typedef logic [BR_PAYLOAD_W-1:0] br_payload_t;

   typedef struct packed {
      logic [BR_ADDR_W-1:0] seq_source;
      br_payload_t          payload;
      logic                 clear;
      logic [BR_ID_W-1:0]   id;
   } br_data_t;

   typedef logic [0:0] br_inj_state_t;
   localparam br_inj_state_t ST_IDLE = 1'b0;
   localparam br_inj_state_t ST_SEND = 1'b1;

endpackage

// File: rtl/br_inject_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module br_rr_arbiter #(
   parameter int unsigned REQ_CNT = 4
) (
   input  logic [REQ_CNT-1:0]         req,
   input  logic [$clog2(REQ_CNT)-1:0] ptr,
   output logic [REQ_CNT-1:0]         gnt,
   output logic [$clog2(REQ_CNT)-1:0] idx,
   output logic                       valid
);

   localparam int unsigned IDX_W = $clog2(REQ_CNT);

   int unsigned j;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int unsigned i = 0; i < REQ_CNT; i++) begin
         j = (32'(ptr) + i) % REQ_CNT;
         if (!valid && req[j]) begin
            valid  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/br_inject_arbiter.sv
// Arbitrates REQ_CNT local requesters onto one BrLite injection port, one flit in flight.
// Optional BR_INJ_STATS_EN adds a saturating count of accepted flits on inj_cnt_o.
module br_inject_arbiter
   import BrLitePkg::*;
#(
   parameter int unsigned REQ_CNT  = 4,
   parameter int unsigned SRC_ADDR = 0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [REQ_CNT-1:0]           req_i,
   input  br_payload_t [REQ_CNT-1:0]    payload_i,
   input  logic [REQ_CNT-1:0]           clear_i,
   output logic [REQ_CNT-1:0]           ack_o,
   output br_data_t                     flit_o,
   output logic                         req_o,
   input  logic                         ack_i,
   input  logic                         busy_i,
`ifdef BR_INJ_STATS_EN
   output logic [31:0]                  inj_cnt_o,
`endif
   output logic [$clog2(REQ_CNT)-1:0]   grant_o
);

   localparam int unsigned IDX_W = $clog2(REQ_CNT);

   br_inj_state_t        state_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [BR_ID_W-1:0]   id_cnt_q;
   logic [REQ_CNT-1:0]   gnt_q;

   logic [REQ_CNT-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 arb_valid;
   logic                 start;
   logic                 done;

   br_rr_arbiter #(
      .REQ_CNT (REQ_CNT)
   ) u_rr (
      .req   (req_i),
      .ptr   (rr_ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign start = (state_q == ST_IDLE) && arb_valid && !busy_i;
   assign done  = (state_q == ST_SEND) && ack_i;

   // Ack follows the NoC accept in the same cycle so the requester drops req_i before
   // the next IDLE cycle can re-arbitrate.
   always_comb begin
      ack_o = '0;
      if (done) ack_o = gnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_cnt_q <= '0;
         gnt_q    <= '0;
         grant_o  <= '0;
         req_o    <= 1'b0;
         flit_o   <= '0;
      end else if (start) begin
         state_q <= ST_SEND;
         req_o   <= 1'b1;
         grant_o <= arb_idx;
         gnt_q   <= arb_gnt;
         flit_o  <= '{seq_source: BR_ADDR_W'(SRC_ADDR),
                      payload:    payload_i[arb_idx],
                      clear:      clear_i[arb_idx],
                      id:         id_cnt_q};
      end else if (done) begin
         state_q  <= ST_IDLE;
         req_o    <= 1'b0;
         id_cnt_q <= id_cnt_q + 1'b1;
         rr_ptr_q <= (grant_o == IDX_W'(REQ_CNT - 1)) ? '0 : grant_o + 1'b1;
      end
   end

`ifdef BR_INJ_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inj_cnt_o <= '0;
      end else if (done && (inj_cnt_o != '1)) begin
         inj_cnt_o <= inj_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_br_inject_arbiter.sv
// Directed bench for br_inject_arbiter (REQ_CNT=4, SRC_ADDR=5); inputs change 1ns after posedge.
module tb_br_inject_arbiter;
   import BrLitePkg::*;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [3:0]            req = '0;
   br_payload_t [3:0]     payload = '0;
   logic [3:0]            clear = '0;
   logic [3:0]            ack_out;
   br_data_t              flit;
   logic                  req_out;
   logic                  ack_in = 1'b0;
   logic                  busy = 1'b0;
   logic [1:0]            grant;
`ifdef BR_INJ_STATS_EN
   logic [31:0]           inj_cnt;
`endif

   int checks = 0;
   int failures = 0;

   br_inject_arbiter #(
      .REQ_CNT  (4),
      .SRC_ADDR (5)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .payload_i (payload),
      .clear_i   (clear),
      .ack_o     (ack_out),
      .flit_o    (flit),
      .req_o     (req_out),
      .ack_i     (ack_in),
      .busy_i    (busy),
`ifdef BR_INJ_STATS_EN
      .inj_cnt_o (inj_cnt),
`endif
      .grant_o   (grant)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0; ack_in = 1'b0; busy = 1'b0; clear = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 20 && req_out !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      req = 4'b1111; busy = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req_out); end
      checks++; if (ack_out !== 4'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack_out); end
      checks++; if (flit !== '0) begin failures++; $display("FAIL reset_flit got=%h exp=0", flit); end
      checks++; if (grant !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant); end
      tick();
      rst = 1'b0; req = '0;
   endtask

   task automatic test_single();
      do_reset();
      payload[2] = 16'hABCD; clear[2] = 1'b1; req = 4'b0100;
      #1;
      checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL single_pre got=%b exp=0", req_out); end
      tick();
      checks++; if (req_out !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", req_out); end
      checks++; if (flit.seq_source !== 8'd5) begin failures++; $display("FAIL single_src got=%0d exp=5", flit.seq_source); end
      checks++; if (flit.id !== 5'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", flit.id); end
      checks++; if (flit.payload !== 16'hABCD || flit.clear !== 1'b1)
         begin failures++; $display("FAIL single_payload got=%h/%b exp=abcd/1", flit.payload, flit.clear); end
      checks++; if (grant !== 2'd2) begin failures++; $display("FAIL single_grant got=%0d exp=2", grant); end
      tick();
      checks++; if (req_out !== 1'b1 || ack_out !== 4'b0)
         begin failures++; $display("FAIL single_hold got=%b/%b exp=1/0000", req_out, ack_out); end
      tick();
      ack_in = 1'b1;
      #1;
      checks++; if (ack_out !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b exp=0100", ack_out); end
      tick();
      ack_in = 1'b0; req = '0;
      #1;
      checks++; if (req_out !== 1'b0 || ack_out !== 4'b0)
         begin failures++; $display("FAIL single_release got=%b/%b exp=0/0000", req_out, ack_out); end
      tick();
      checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", req_out); end
      clear = '0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g;
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_g = 2'(k % 4);
         wait_req();
         checks++; if (req_out !== 1'b1) begin failures++; $display("FAIL rr_timeout k=%0d got=%b exp=1", k, req_out); end
         checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant, exp_g); end
         checks++; if (flit.id !== 5'(k)) begin failures++; $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, flit.id, k); end
         ack_in = 1'b1;
         #1;
         checks++; if (ack_out !== (4'b0001 << exp_g))
            begin failures++; $display("FAIL rr_ack k=%0d got=%b exp=%b", k, ack_out, 4'b0001 << exp_g); end
         tick();
         ack_in = 1'b0;
         #1;
         checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL rr_gap k=%0d got=%b exp=0", k, req_out); end
      end
      req = '0;
   endtask

   task automatic test_busy();
      do_reset();
      busy = 1'b1; req = 4'b0010;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL busy_hold k=%0d got=%b exp=0", k, req_out); end
      end
      busy = 1'b0;
      tick();
      checks++; if (req_out !== 1'b1 || grant !== 2'd1)
         begin failures++; $display("FAIL busy_release got=%b/%0d exp=1/1", req_out, grant); end
      busy = 1'b1;
      tick();
      checks++; if (req_out !== 1'b1) begin failures++; $display("FAIL busy_in_send got=%b exp=1", req_out); end
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0; req = '0; busy = 1'b0;
   endtask

   task automatic test_id_wrap();
      do_reset();
      req = 4'b0001;
      for (int k = 0; k < 33; k++) begin
         wait_req();
         checks++; if (req_out !== 1'b1 || flit.id !== 5'(k % 32))
            begin failures++; $display("FAIL wrap_id k=%0d got=%b/%0d exp=1/%0d", k, req_out, flit.id, k % 32); end
         ack_in = 1'b1;
         tick();
         ack_in = 1'b0;
      end
      req = '0;
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      req = 4'b1000;
      wait_req();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
      wait_req();
      checks++; if (flit.id !== 5'd1) begin failures++; $display("FAIL midrst_pre_id got=%0d exp=1", flit.id); end
      rst = 1'b1; ack_in = 1'b1;
      #1;
      checks++; if (req_out !== 1'b0) begin failures++; $display("FAIL midrst_req got=%b exp=0", req_out); end
      checks++; if (ack_out !== 4'b0) begin failures++; $display("FAIL midrst_ack got=%b exp=0000", ack_out); end
      tick();
      rst = 1'b0; ack_in = 1'b0;
      wait_req();
      checks++; if (req_out !== 1'b1 || flit.id !== 5'd0 || grant !== 2'd3)
         begin failures++; $display("FAIL midrst_next got=%b/%0d/%0d exp=1/0/3", req_out, flit.id, grant); end
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0; req = '0;
   endtask

`ifdef BR_INJ_STATS_EN
   task automatic test_stats();
      do_reset();
      req = 4'b0010;
      for (int k = 0; k < 7; k++) begin
         wait_req();
         ack_in = 1'b1;
         tick();
         ack_in = 1'b0;
      end
      req = '0;
      tick();
      checks++; if (inj_cnt !== 32'd7) begin failures++; $display("FAIL stats_cnt got=%0d exp=7", inj_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_busy();
      test_id_wrap();
      test_reset_mid_send();
`ifdef BR_INJ_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
